// File: rtl/fp_conv_pkg.sv
// Shared constants for the fixed-point to 1/3/4 mini-float converter:
// FSM state codes, format limits and the normalize/round bit positions.
package fp_conv_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ABS   = 3'd1;
    localparam logic [2:0] ST_NORM  = 3'd2;
    localparam logic [2:0] ST_ROUND = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Format limits
    localparam logic [2:0] EXP_MAX = 3'd7;
    localparam logic [3:0] SIG_MAX = 4'hF;
    localparam logic [3:0] SIG_OVF = 4'h8;

    // Magnitude bit that marks a normalized value, and the bit just below
    // the 4-bit significand window that decides rounding.
    localparam int NORM_BIT = 10;
    localparam int RND_BIT  = 6;

    // Fixed input width and the saturation pair for the most negative input.
    localparam int          IN_W    = 12;
    localparam logic [11:0] IN_MIN  = 12'h800;
    localparam logic [11:0] MAG_MAX = 12'h7FF;

endpackage

// File: rtl/fp_round_stage.sv
// Combinational round-half-up of a 4-bit significand with exponent carry.
// Overflow at the largest exponent saturates to the largest finite value.
module fp_round_stage
    import fp_conv_pkg::*;
(
    input  logic [2:0] exp,
    input  logic [3:0] sig,
    input  logic       rnd,
    output logic [2:0] exp_r,
    output logic [3:0] sig_r
);

    // Apply the round bit; carry-out of the significand bumps the exponent
    always_comb begin
        exp_r = exp;
        sig_r = sig;
        if (rnd) begin
            if (sig != SIG_MAX) begin
                sig_r = sig + 4'd1;
            end else if (exp != EXP_MAX) begin
                sig_r = SIG_OVF;
                exp_r = exp + 3'd1;
            end
            // sig all ones at the top exponent: leave it saturated
        end
    end

endmodule

// File: rtl/fp_convert_ctrl.sv
// Sequenced 12-bit two's-complement to 1/3/4 mini-float converter.
// One sample at a time: capture, take magnitude, normalize one bit per
// cycle, round, then hold the result until the consumer takes it.
module fp_convert_ctrl
    import fp_conv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] d_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        s_out,
    output logic [2:0]  e_out,
    output logic [3:0]  f_out,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [2:0]      state;
    logic [IN_W-1:0] d_q;
    logic [IN_W-1:0] mag;
    logic [2:0]      exp_q;
    logic            sign_q;
    logic [2:0]      exp_r;
    logic [3:0]      sig_r;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    fp_round_stage u_round (
        .exp   (exp_q),
        .sig   (mag[NORM_BIT:NORM_BIT-3]),
        .rnd   (mag[RND_BIT]),
        .exp_r (exp_r),
        .sig_r (sig_r)
    );

    // Conversion sequencer and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            d_q    <= '0;
            mag    <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            s_out  <= 1'b0;
            e_out  <= '0;
            f_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        d_q   <= d_in;
                        state <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    sign_q <= d_q[IN_W-1];
                    // -2048 has no positive 12-bit twin; clamp to +2047
                    if (d_q == IN_MIN)
                        mag <= MAG_MAX;
                    else if (d_q[IN_W-1])
                        mag <= ~d_q + 12'd1;
                    else
                        mag <= d_q;
                    exp_q <= EXP_MAX;
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    if (mag[NORM_BIT] || exp_q == 3'd0) begin
                        state <= ST_ROUND;
                    end else begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 3'd1;
                    end
                end
                ST_ROUND: begin
                    s_out <= sign_q;
                    e_out <= exp_r;
                    f_out <= sig_r;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_convert_ctrl.md
Name: fp_convert_ctrl

Overview:
- Sequenced 12-bit two's-complement to 8-bit floating-point converter (1 sign, 3-bit exponent E, 4-bit significand F).
- Accepts one sample over a valid/ready handshake.
- Computes magnitude, then normalizes with one shift per cycle, then rounds through a combinational rounding sub-module.
- Presents the result on a held valid/ready output handshake. Sits between the switch/input capture logic and the display driver.

Parameters:
- None. Widths are fixed by the format: 12-bit input, 1/3/4-bit output.
- State encodings and constants are localparams from the shared package.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- d_in  input  12  two's-complement sample
- in_valid  input  1  d_in is valid
- in_ready  output  1  block can accept a sample; high only in IDLE
- s_out  output  1  sign bit of the result
- e_out  output  3  exponent of the result
- f_out  output  4  significand of the result
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts the result

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; s_out=0; e_out=0; f_out=0; internal mag/exp registers cleared. Reset applies immediately in any state and discards any in-flight conversion.
- States: IDLE, ABS, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch d_in and go to ABS. Otherwise stay.
- ABS (1 cycle):
  - sign = d[11].
  - mag = sign ? -d : d, in 12 bits.
  - d=12'h800 saturates to mag=12'h7FF with sign=1.
  - Load exp=7, then go to NORM.
- NORM (k+1 cycles, k = shifts, 0..7):
  - If mag[10]==1 or exp==0, go to ROUND.
  - Else mag <= mag<<1 (zero fill) and exp <= exp-1; stay in NORM.
- ROUND (1 cycle):
  - Feed exp, mag[10:7] and round bit mag[6] to the rounding stage.
  - Round bit 0: E=exp, F=mag[10:7].
  - Round bit 1 and F!=1111: F+1.
  - Round bit 1, F==1111 and exp!=7: F=1000, E=exp+1.
  - Round bit 1, F==1111 and exp==7: saturate; E=111, F=1111 unchanged.
  - Register s_out/e_out/f_out on exit, then go to DONE.
- DONE:
  - out_valid=1; outputs held stable; in_ready=0.
  - On out_ready, go to IDLE. out_valid drops the following cycle.
  - s_out/e_out/f_out keep their last value until the next ROUND.
- Latency: out_valid rises k+3 rising edges after the accept edge, where k = (leading zeros of mag) - 1, clamped to 0..7. Range is 3..10 cycles.
- Throughput: at most one conversion in flight. in_valid while busy is ignored; nothing is queued.
- Exponent 0: F holds mag[3:0] directly. The round bit is the shifted-in 0, so no rounding occurs.
- Simultaneous rst and any handshake: rst wins.

Decomposition:
- Package fp_conv_pkg:
  - state enum/localparams IDLE..DONE
  - EXP_MAX=3'd7, SIG_MAX=4'hF, SIG_OVF=4'h8
  - NORM_BIT=10, RND_BIT=6
- Sub-module fp_round_stage (purely combinational):
  - inputs: exp[2:0], sig[3:0], rnd
  - outputs: exp_r[2:0], sig_r[3:0]
  - implements the three ROUND rules and the saturation rule
  - verified standalone, exhaustively (256 combinations)

Test Plan:
1. d_in=12'h000 -> S=0, E=000, F=0000; out_valid 10 edges after accept (k=7).
2. d_in=12'd422 -> S=0, E=101, F=1101; no round; latency 5 (k=2).
3. d_in=12'd125 -> significand overflow on round: S=0, E=100, F=1000; latency 7.
4. Saturation:
   - d_in=12'h800 -> S=1, E=111, F=1111.
   - d_in=12'h7FF -> S=0, E=111, F=1111.
   - Both have latency 3.
5. d_in=12'hF00 (-256) -> S=1, E=101, F=1000.
6. Backpressure and reset, with d_in=12'd422:
   - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0, a pulsed in_valid is ignored.
   - Then set out_ready=1: IDLE next cycle.
   - Separately, assert rst during NORM: immediately IDLE with all outputs 0 and in_ready=1.
